floo_hbm_ch_demux: RTL and testbench
====================================

FLOO_HBM_CH_DEMUX -- requirements
Module: floo_hbm_ch_demux

Interface
REQ-001 SHALL have parameter NumChannels, default 4: number of HBM pseudo-channels (1..16).
REQ-002 SHALL have parameter InterleaveBit, default 12: lowest address bit of the channel-select field.
REQ-003 SHALL have parameter MaxTxns, default 8: maximum outstanding transactions per direction (read, write).
REQ-004 SHALL have type parameter axi_req_t, default axi_wide_out_req_t: AXI request bundle.
REQ-005 SHALL have type parameter axi_rsp_t, default axi_wide_out_rsp_t: AXI response bundle.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port slv_req_i, input, axi_req_t: upstream AXI requests from the NI.
REQ-009 SHALL have port slv_rsp_o, output, axi_rsp_t: upstream AXI responses to the NI.
REQ-010 SHALL have port mst_req_o, output, axi_req_t [NumChannels]: per-channel requests to HBM.
REQ-011 SHALL have port mst_rsp_i, input, axi_rsp_t [NumChannels]: per-channel responses from HBM.
REQ-012 SHALL have port idle_o, output, 1 bit: high when no read or write transaction is outstanding.

Function
REQ-013 SHALL select the channel as addr[InterleaveBit +: SelW], SelW = max(1, clog2(NumChannels)); with NumChannels=1 the select SHALL be 0.
REQ-014 SHALL route each burst whole to the channel of its start address, with no splitting; bursts crossing an interleave granule are an upstream protocol violation, flagged by a simulation assertion.
REQ-015 SHALL keep per direction a counter cnt (0..MaxTxns, width clog2(MaxTxns+1)) and a channel register ch.
REQ-016 SHALL treat each direction as FSM IDLE (cnt=0), ACTIVE (0<cnt<MaxTxns), FULL (cnt=MaxTxns).
REQ-017 SHALL accept a new AR/AW only if IDLE, or ACTIVE with select equal to ch; FULL, or ACTIVE with a different select, SHALL stall with ready=0 upstream and valid=0 to every channel.
REQ-018 SHALL forward AR/AW combinationally (0 cycles) to the selected channel only, with ready taken from that channel; ch SHALL load the select on an accepted handshake.
REQ-019 SHALL increment rd cnt on an AR handshake and decrement it on an R handshake with last=1; both in one cycle SHALL leave cnt unchanged.
REQ-020 SHALL increment wr cnt on an AW handshake and decrement it on a B handshake; both in one cycle SHALL leave cnt unchanged.
REQ-021 SHALL keep w_pend (0..MaxTxns), incremented on AW handshake and decremented on W handshake with last=1.
REQ-022 SHALL forward W only to wr ch and only while w_pend>0, or while an AW handshake occurs in the same cycle; otherwise W ready=0.
REQ-023 SHALL forward R and B combinationally from the rd/wr ch channel only while the respective cnt>0; all other channels SHALL see r_ready=0 and b_ready=0.
REQ-024 SHALL never let a valid already presented downstream drop before its handshake; ch SHALL be stable while cnt>0.
REQ-025 SHALL assert idle_o combinationally when rd cnt, wr cnt and w_pend are all 0.

Reset
REQ-026 SHALL, while rst_ni=0, clear cnt, w_pend and ch to 0 in both directions, drive all mst valids and slv readies to 0, and drive idle_o=1.
REQ-027 SHALL, on reset mid-transaction, discard all tracking state; in-flight bursts are lost, and the first post-reset request is treated as IDLE.

Verification
REQ-028 SHALL check: AR addr 0x3000, len 3 -> mst_req_o[3] only; after 4 R beats, rd cnt 1->0 and idle_o=1.
REQ-029 SHALL check: AR 0x1000 outstanding, then AR 0x2000 -> second AR stalls until the first R last, then goes to channel 2.
REQ-030 SHALL check: 8 ARs to 0x0000 with R held off -> the 9th stalls (FULL); one R last releases it in the same cycle.
REQ-031 SHALL check: W presented before AW -> W ready=0; AW 0x1000 accepted -> W beats go to channel 1; B decrements wr cnt.
REQ-032 SHALL check: AR handshake coincident with R last on the same channel -> cnt unchanged; rst_ni pulsed with cnt=3 -> cnt=0, idle_o=1.

Source files
------------

// File: rtl/floo_hbm_ch_demux.sv
// HBM pseudo-channel demux: steers whole AXI bursts to the channel picked by the
// interleave bits of their start address and tracks outstanding reads/writes per direction.
package floo_hbm_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_wide_out_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        axi_b_t  b;
        logic    r_valid;
        axi_r_t  r;
    } axi_wide_out_rsp_t;
endpackage

module floo_hbm_ch_demux #(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned InterleaveBit = 12,
    parameter int unsigned MaxTxns       = 8,
    parameter type axi_req_t = floo_hbm_pkg::axi_wide_out_req_t,
    parameter type axi_rsp_t = floo_hbm_pkg::axi_wide_out_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_rsp_o,
    output axi_req_t mst_req_o [NumChannels],
    input  axi_rsp_t mst_rsp_i [NumChannels],
    output logic     idle_o
);
    localparam int unsigned SelW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntW = $clog2(MaxTxns + 1);

    typedef logic [SelW-1:0] sel_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} dir_state_e;

    localparam cnt_t CntMax = cnt_t'(MaxTxns);

    function automatic dir_state_e state_of(input cnt_t c);
        if (c == '0)     return IDLE;
        if (c == CntMax) return FULL;
        return ACTIVE;
    endfunction

    cnt_t       rd_cnt, wr_cnt, w_pend;
    sel_t       rd_ch, wr_ch;
    sel_t       ar_sel, aw_sel, w_tgt;
    dir_state_e rd_st, wr_st;
    logic       ar_rdy_ch, aw_rdy_ch, w_rdy_ch, r_vld_ch, r_last_ch, b_vld_ch;
    logic       rd_can, wr_can, r_ok, b_ok, w_ok;
    logic       ar_hs, aw_hs, w_done, r_done, b_hs;
    logic       ar_in_range, aw_in_range;

    if (NumChannels > 1) begin : g_sel
        assign ar_sel = slv_req_i.ar.addr[InterleaveBit +: SelW];
        assign aw_sel = slv_req_i.aw.addr[InterleaveBit +: SelW];
    end else begin : g_sel_single
        assign ar_sel = '0;
        assign aw_sel = '0;
    end

    assign ar_in_range = 32'(ar_sel) < NumChannels;
    assign aw_in_range = 32'(aw_sel) < NumChannels;
    assign rd_st       = state_of(rd_cnt);
    assign wr_st       = state_of(wr_cnt);

    // Channel-side muxes; W is kept apart because its target depends on the AW handshake.
    always_comb begin
        ar_rdy_ch = 1'b0;
        aw_rdy_ch = 1'b0;
        r_vld_ch  = 1'b0;
        r_last_ch = 1'b0;
        b_vld_ch  = 1'b0;
        for (int i = 0; i < NumChannels; i++) begin
            if (ar_sel == sel_t'(i)) ar_rdy_ch = mst_rsp_i[i].ar_ready;
            if (aw_sel == sel_t'(i)) aw_rdy_ch = mst_rsp_i[i].aw_ready;
            if (rd_ch == sel_t'(i)) begin
                r_vld_ch  = mst_rsp_i[i].r_valid;
                r_last_ch = mst_rsp_i[i].r.last;
            end
            if (wr_ch == sel_t'(i)) b_vld_ch = mst_rsp_i[i].b_valid;
        end
    end

    always_comb begin
        w_rdy_ch = 1'b0;
        for (int i = 0; i < NumChannels; i++)
            if (w_tgt == sel_t'(i)) w_rdy_ch = mst_rsp_i[i].w_ready;
    end

    assign r_ok   = rst_ni && (rd_st != IDLE);
    assign b_ok   = rst_ni && (wr_st != IDLE);
    assign r_done = r_ok && r_vld_ch && slv_req_i.r_ready && r_last_ch;
    assign b_hs   = b_ok && b_vld_ch && slv_req_i.b_ready;

    // A full direction frees a slot in the same cycle its retiring response completes.
    assign rd_can = rst_ni && ar_in_range &&
                    (rd_st == IDLE || (ar_sel == rd_ch && (rd_st == ACTIVE || r_done)));
    assign wr_can = rst_ni && aw_in_range &&
                    ((wr_st == IDLE && w_pend == '0) ||
                     (aw_sel == wr_ch && (wr_st == ACTIVE || b_hs) && w_pend != CntMax));

    assign ar_hs  = slv_req_i.ar_valid && ar_rdy_ch && rd_can;
    assign aw_hs  = slv_req_i.aw_valid && aw_rdy_ch && wr_can;
    assign w_tgt  = (w_pend != '0) ? wr_ch : aw_sel;
    assign w_ok   = rst_ni && (w_pend != '0 || aw_hs);
    assign w_done = w_ok && slv_req_i.w_valid && w_rdy_ch && slv_req_i.w.last;

    always_comb begin
        slv_rsp_o          = '0;
        slv_rsp_o.ar_ready = ar_rdy_ch && rd_can;
        slv_rsp_o.aw_ready = aw_rdy_ch && wr_can;
        slv_rsp_o.w_ready  = w_rdy_ch && w_ok;
        slv_rsp_o.r_valid  = r_vld_ch && r_ok;
        slv_rsp_o.b_valid  = b_vld_ch && b_ok;
        for (int i = 0; i < NumChannels; i++) begin
            if (rd_ch == sel_t'(i)) slv_rsp_o.r = mst_rsp_i[i].r;
            if (wr_ch == sel_t'(i)) slv_rsp_o.b = mst_rsp_i[i].b;
        end
    end

    always_comb begin
        for (int i = 0; i < NumChannels; i++) begin
            mst_req_o[i]          = slv_req_i;
            mst_req_o[i].ar_valid = slv_req_i.ar_valid && rd_can && (ar_sel == sel_t'(i));
            mst_req_o[i].aw_valid = slv_req_i.aw_valid && wr_can && (aw_sel == sel_t'(i));
            mst_req_o[i].w_valid  = slv_req_i.w_valid && w_ok && (w_tgt == sel_t'(i));
            mst_req_o[i].r_ready  = slv_req_i.r_ready && r_ok && (rd_ch == sel_t'(i));
            mst_req_o[i].b_ready  = slv_req_i.b_ready && b_ok && (wr_ch == sel_t'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            w_pend <= '0;
            rd_ch  <= '0;
            wr_ch  <= '0;
        end else begin
            if (ar_hs) rd_ch <= ar_sel;
            if (aw_hs) wr_ch <= aw_sel;
            rd_cnt <= rd_cnt + cnt_t'(ar_hs) - cnt_t'(r_done);
            wr_cnt <= wr_cnt + cnt_t'(aw_hs) - cnt_t'(b_hs);
            w_pend <= w_pend + cnt_t'(aw_hs) - cnt_t'(w_done);
        end
    end

    assign idle_o = (rd_cnt == '0) && (wr_cnt == '0) && (w_pend == '0);

    // Bursts are never split, so an INCR burst must stay inside one interleave granule.
    logic [63:0] ar_beg, ar_end, aw_beg, aw_end;
    assign ar_beg = 64'(slv_req_i.ar.addr);
    assign aw_beg = 64'(slv_req_i.aw.addr);
    assign ar_end = ar_beg + ((64'(slv_req_i.ar.len) + 64'd1) << slv_req_i.ar.size) - 64'd1;
    assign aw_end = aw_beg + ((64'(slv_req_i.aw.len) + 64'd1) << slv_req_i.aw.size) - 64'd1;

    a_ar_granule: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.ar_valid && slv_req_i.ar.burst == 2'b01) |->
        ((ar_end >> InterleaveBit) == (ar_beg >> InterleaveBit)));
    a_aw_granule: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_i.aw_valid && slv_req_i.aw.burst == 2'b01) |->
        ((aw_end >> InterleaveBit) == (aw_beg >> InterleaveBit)));
    a_rd_ch_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rd_cnt != '0) |=> $stable(rd_ch));
    a_wr_ch_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_cnt != '0 || w_pend != '0) |=> $stable(wr_ch));
endmodule

// File: tb/tb_floo_hbm_ch_demux.sv
// Directed bench for floo_hbm_ch_demux: stimulus pushes expected channel routing into
// queues, a negedge monitor pops and compares every downstream AR/AW/W handshake.
module tb_floo_hbm_ch_demux;
    import floo_hbm_pkg::*;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    axi_wide_out_req_t slv_req;
    axi_wide_out_rsp_t slv_rsp;
    axi_wide_out_req_t mst_req [NCH];
    axi_wide_out_rsp_t mst_rsp [NCH];
    logic              idle;

    always #5 clk = ~clk;

    floo_hbm_ch_demux #(.NumChannels(NCH), .InterleaveBit(12), .MaxTxns(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .slv_req_i(slv_req),
        .slv_rsp_o(slv_rsp),
        .mst_req_o(mst_req),
        .mst_rsp_i(mst_rsp),
        .idle_o   (idle)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int ch; logic [31:0] addr; } exp_ax_t;
    exp_ax_t exp_ar_q[$];
    exp_ax_t exp_aw_q[$];
    int      exp_w_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    exp_ax_t me;
    int      mw;
    int      nv;
    always @(negedge clk) if (rst_n) begin
        nv = 0;
        for (int i = 0; i < NCH; i++) nv += int'(mst_req[i].ar_valid);
        if (nv != 0) chk("ar_onehot", 64'(nv), 64'd1);
        for (int i = 0; i < NCH; i++) begin
            if (mst_req[i].ar_valid && mst_rsp[i].ar_ready) begin
                chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                if (exp_ar_q.size() != 0) begin
                    me = exp_ar_q.pop_front();
                    chk("ar_chan", 64'(i), 64'(me.ch));
                    chk("ar_addr", 64'(mst_req[i].ar.addr), 64'(me.addr));
                end
            end
            if (mst_req[i].aw_valid && mst_rsp[i].aw_ready) begin
                chk("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
                if (exp_aw_q.size() != 0) begin
                    me = exp_aw_q.pop_front();
                    chk("aw_chan", 64'(i), 64'(me.ch));
                    chk("aw_addr", 64'(mst_req[i].aw.addr), 64'(me.addr));
                end
            end
            if (mst_req[i].w_valid && mst_rsp[i].w_ready) begin
                chk("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) begin
                    mw = exp_w_q.pop_front();
                    chk("w_chan", 64'(i), 64'(mw));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input int ch);
        int t = 0;
        exp_ar_q.push_back('{ch, addr});
        slv_req.ar.addr  = addr;
        slv_req.ar.len   = len;
        slv_req.ar.size  = 3'd3;
        slv_req.ar.burst = 2'b01;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        while (!slv_rsp.ar_ready && t < 50) begin t++; @(negedge clk); end
        chk("ar_accept_in_time", 64'(t < 50), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic send_r(input int ch, input logic last, input logic [63:0] data);
        int t = 0;
        mst_rsp[ch].r_valid = 1'b1;
        mst_rsp[ch].r.last  = last;
        mst_rsp[ch].r.data  = data;
        @(negedge clk);
        while (!mst_req[ch].r_ready && t < 50) begin t++; @(negedge clk); end
        chk("r_ready_in_time", 64'(t < 50), 64'd1);
        chk("r_up_valid", 64'(slv_rsp.r_valid), 64'd1);
        chk("r_up_data", slv_rsp.r.data, data);
        tick();
        mst_rsp[ch].r_valid = 1'b0;
        mst_rsp[ch].r.last  = 1'b0;
    endtask

    task automatic send_b(input int ch);
        int t = 0;
        mst_rsp[ch].b_valid = 1'b1;
        @(negedge clk);
        while (!mst_req[ch].b_ready && t < 50) begin t++; @(negedge clk); end
        chk("b_ready_in_time", 64'(t < 50), 64'd1);
        chk("b_up_valid", 64'(slv_rsp.b_valid), 64'd1);
        tick();
        mst_rsp[ch].b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic any_mst;
    initial begin
        // Reset with every valid forced high so the gating is actually exercised.
        rst_n   = 1'b0;
        slv_req = '0;
        for (int i = 0; i < NCH; i++) begin
            mst_rsp[i]          = '0;
            mst_rsp[i].ar_ready = 1'b1;
            mst_rsp[i].aw_ready = 1'b1;
            mst_rsp[i].w_ready  = 1'b1;
        end
        mst_rsp[0].r_valid = 1'b1;
        mst_rsp[0].b_valid = 1'b1;
        slv_req.r_ready    = 1'b1;
        slv_req.b_ready    = 1'b1;
        slv_req.ar_valid   = 1'b1;
        slv_req.aw_valid   = 1'b1;
        slv_req.w_valid    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_ar_ready", 64'(slv_rsp.ar_ready), 64'd0);
        chk("rst_aw_ready", 64'(slv_rsp.aw_ready), 64'd0);
        chk("rst_w_ready", 64'(slv_rsp.w_ready), 64'd0);
        chk("rst_r_valid", 64'(slv_rsp.r_valid), 64'd0);
        any_mst = 1'b0;
        for (int i = 0; i < NCH; i++)
            any_mst |= mst_req[i].ar_valid | mst_req[i].aw_valid | mst_req[i].w_valid |
                       mst_req[i].r_ready | mst_req[i].b_ready;
        chk("rst_mst_quiet", 64'(any_mst), 64'd0);
        slv_req.ar_valid   = 1'b0;
        slv_req.aw_valid   = 1'b0;
        slv_req.w_valid    = 1'b0;
        mst_rsp[0].r_valid = 1'b0;
        mst_rsp[0].b_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // AR 0x3000 len 3 -> channel 3, four beats retire it.
        send_ar(32'h3000, 8'd3, 3);
        @(negedge clk);
        chk("t1_rd_cnt_1", 64'(dut.rd_cnt), 64'd1);
        chk("t1_busy", 64'(idle), 64'd0);
        tick();
        for (int b = 0; b < 4; b++) send_r(3, b == 3, 64'hA0 + 64'(b));
        @(negedge clk);
        chk("t1_rd_cnt_0", 64'(dut.rd_cnt), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        tick();

        // Second AR to another channel waits for the first read to finish.
        send_ar(32'h1000, 8'd0, 1);
        fork
            send_ar(32'h2000, 8'd0, 2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_stall_ready", 64'(slv_rsp.ar_ready), 64'd0);
                    chk("t2_stall_ch2_valid", 64'(mst_req[2].ar_valid), 64'd0);
                end
                tick();
                send_r(1, 1'b1, 64'hB1);
            end
        join
        @(negedge clk);
        chk("t2_rd_cnt", 64'(dut.rd_cnt), 64'd1);
        tick();
        send_r(2, 1'b1, 64'hB2);

        // Fill to 8 outstanding, the 9th stalls until an R last frees a slot that same cycle.
        for (int k = 0; k < 8; k++) send_ar(32'h0000, 8'd0, 0);
        @(negedge clk);
        chk("t3_rd_cnt_full", 64'(dut.rd_cnt), 64'd8);
        tick();
        exp_ar_q.push_back('{0, 32'h0000});
        slv_req.ar_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t3_full_stall", 64'(slv_rsp.ar_ready), 64'd0);
        end
        tick();
        mst_rsp[0].r_valid = 1'b1;
        mst_rsp[0].r.last  = 1'b1;
        @(negedge clk);
        chk("t3_release_same_cycle", 64'(slv_rsp.ar_ready), 64'd1);
        chk("t3_r_ready", 64'(mst_req[0].r_ready), 64'd1);
        tick();
        slv_req.ar_valid   = 1'b0;
        mst_rsp[0].r_valid = 1'b0;
        mst_rsp[0].r.last  = 1'b0;
        @(negedge clk);
        chk("t3_rd_cnt_still_full", 64'(dut.rd_cnt), 64'd8);
        tick();
        for (int k = 0; k < 8; k++) send_r(0, 1'b1, 64'hC0 + 64'(k));
        @(negedge clk);
        chk("t3_idle", 64'(idle), 64'd1);
        tick();

        // W ahead of AW is held off, then follows AW 0x1000 to channel 1.
        slv_req.w.data  = 64'hD0;
        slv_req.w.last  = 1'b0;
        slv_req.w_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t4_w_held", 64'(slv_rsp.w_ready), 64'd0);
            any_mst = 1'b0;
            for (int i = 0; i < NCH; i++) any_mst |= mst_req[i].w_valid;
            chk("t4_w_not_forwarded", 64'(any_mst), 64'd0);
        end
        tick();
        exp_aw_q.push_back('{1, 32'h1000});
        exp_w_q.push_back(1);
        exp_w_q.push_back(1);
        slv_req.aw.addr  = 32'h1000;
        slv_req.aw.len   = 8'd1;
        slv_req.aw.size  = 3'd3;
        slv_req.aw.burst = 2'b01;
        slv_req.aw_valid = 1'b1;
        @(negedge clk);
        chk("t4_aw_ready", 64'(slv_rsp.aw_ready), 64'd1);
        chk("t4_w_with_aw", 64'(slv_rsp.w_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data   = 64'hD1;
        slv_req.w.last   = 1'b1;
        @(negedge clk);
        chk("t4_w_last_ready", 64'(slv_rsp.w_ready), 64'd1);
        chk("t4_w_ch1_valid", 64'(mst_req[1].w_valid), 64'd1);
        tick();
        slv_req.w_valid = 1'b0;
        slv_req.w.last  = 1'b0;
        @(negedge clk);
        chk("t4_wr_cnt_1", 64'(dut.wr_cnt), 64'd1);
        chk("t4_w_pend_0", 64'(dut.w_pend), 64'd0);
        chk("t4_busy", 64'(idle), 64'd0);
        tick();
        send_b(1);
        @(negedge clk);
        chk("t4_wr_cnt_0", 64'(dut.wr_cnt), 64'd0);
        chk("t4_idle", 64'(idle), 64'd1);
        tick();

        // Coincident AR and R last keep the count; reset mid-flight drops everything.
        send_ar(32'h0000, 8'd0, 0);
        send_ar(32'h0000, 8'd0, 0);
        exp_ar_q.push_back('{0, 32'h0000});
        slv_req.ar_valid   = 1'b1;
        mst_rsp[0].r_valid = 1'b1;
        mst_rsp[0].r.last  = 1'b1;
        @(negedge clk);
        chk("t5_ar_ready", 64'(slv_rsp.ar_ready), 64'd1);
        chk("t5_r_ready", 64'(mst_req[0].r_ready), 64'd1);
        tick();
        slv_req.ar_valid   = 1'b0;
        mst_rsp[0].r_valid = 1'b0;
        mst_rsp[0].r.last  = 1'b0;
        @(negedge clk);
        chk("t5_rd_cnt_same", 64'(dut.rd_cnt), 64'd2);
        tick();
        send_ar(32'h0000, 8'd0, 0);
        @(negedge clk);
        chk("t5_rd_cnt_3", 64'(dut.rd_cnt), 64'd3);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_rd_cnt", 64'(dut.rd_cnt), 64'd0);
        chk("t5_rst_idle", 64'(idle), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send_ar(32'h2000, 8'd0, 2);
        @(negedge clk);
        chk("t5_post_rst_cnt", 64'(dut.rd_cnt), 64'd1);
        tick();
        send_r(2, 1'b1, 64'hE2);
        @(negedge clk);
        chk("t5_final_idle", 64'(idle), 64'd1);
        chk("exp_ar_drained", 64'(exp_ar_q.size()), 64'd0);
        chk("exp_aw_drained", 64'(exp_aw_q.size()), 64'd0);
        chk("exp_w_drained", 64'(exp_w_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
